link_align_ctrl: RTL and testbench
==================================

LINK_ALIGN_CTRL -- requirements
Module: link_align_ctrl

Interface
REQ-001 Parameter: DWIDTH, 6, width of the deserializer delay code; codes 0..2^DWIDTH-1 are scanned.
REQ-002 Parameter: RSTCYC, 8, cycles the deserializer reset is held low per step.
REQ-003 Parameter: SETTLE, 64, wait cycles after reset release before judging a delay.
REQ-004 Parameter: DWELL, 256, judging-window length in cycles.
REQ-005 Parameter: LOSSCYC, 16, consecutive cycles with aligned low in LOCKED that trigger a rescan.
REQ-006 Ports (name, direction, width, meaning):
 clk  in  1  single clock for all logic.
 reset  in  1  asynchronous, active-low.
 start  in  1  one-cycle request to begin a scan.
 aligned  in  1  alignment flag from the data extractor.
 errorCount  in  6  error counter from the data extractor.
 delay  out  DWIDTH  delay code driven to the deserializer.
 desrReset  out  1  active-low reset to the deserializer and extractor.
 busy  out  1  scan in progress.
 locked  out  1  final delay applied and link aligned.
 fail  out  1  last scan found no passing code.
 bestDelay  out  DWIDTH  chosen code.
 relockCount  out  8  number of automatic rescans, saturating.

Function
REQ-007 States: IDLE, RST, SETTLE, DWELL, NEXT, APPLY, LOCKED, FAIL; all outputs registered.
REQ-008 IDLE: start=1 -> delay<=0, run trackers cleared, go to RST; busy=1 from the next cycle.
REQ-009 RST: desrReset=0 for exactly RSTCYC cycles, then SETTLE; desrReset=1 in every other state.
REQ-010 SETTLE: wait exactly SETTLE cycles, then DWELL; errorCount is sampled on the entry cycle into DWELL.
REQ-011 DWELL: over DWELL cycles a code passes only if aligned=1 on every cycle and errorCount on the last cycle equals the entry sample.
REQ-012 NEXT, one cycle: update the current run of consecutive passing codes and the best run.
REQ-013 Best run is the longest run; ties keep the earlier run; runs do not wrap from the top code to 0.
REQ-014 NEXT exit: if delay < 2^DWIDTH-1, delay increments and the FSM goes to RST; otherwise it goes to APPLY, or to FAIL if no code passed.
REQ-015 APPLY: bestDelay = runStart + (runLen-1)>>1 (floor of the centre); drive delay<=bestDelay; run one RST+SETTLE sequence, then go to LOCKED.
REQ-016 LOCKED: locked=1, busy=0.
REQ-017 LOCKED loss: aligned=0 for LOSSCYC consecutive cycles -> locked=0, relockCount+1 (saturates at 255), restart the scan as in REQ-008; any aligned=1 clears the loss counter.
REQ-018 FAIL: fail=1, busy=0, delay holds at 2^DWIDTH-1; start returns to the REQ-008 behaviour and clears fail.
REQ-019 start is ignored while busy=1 or in LOCKED.
REQ-020 An all-pass scan gives runStart=0, runLen=2^DWIDTH, bestDelay=2^(DWIDTH-1)-1 (31 for DWIDTH=6).
REQ-021 A single passing code k gives bestDelay=k.

Reset
REQ-022 While reset=0: state=IDLE; delay=0; desrReset=0; busy=0; locked=0; fail=0; bestDelay=0; relockCount=0; all counters=0.
REQ-023 reset asserted mid-scan aborts immediately to the REQ-022 values.
REQ-024 After reset release: desrReset goes to 1 on the first clk edge; no scan starts until start=1.

Verification
REQ-025 Behavioural link model, aligned=1 only for codes 10..20, errorCount constant; pulse start -> 64 steps, locked=1, bestDelay=15, fail=0.
REQ-026 Two windows, 5..8 and 40..49 -> bestDelay=44; tie windows 2..4 and 30..32 -> bestDelay=3.
REQ-027 aligned always 0 -> fail=1, locked=0, busy=0, delay=63; a second start rescans.
REQ-028 After lock, force aligned=0 for 15 cycles -> still locked; for 16 cycles -> locked=0, relockCount=1, delay restarts at 0.
REQ-029 errorCount increments once inside the DWELL of code 12 within window 10..20 -> code 12 fails, best run 13..20, bestDelay=16.
REQ-030 Assert reset during the DWELL of code 30 -> all outputs take the REQ-022 values on that cycle; desrReset low for exactly RSTCYC cycles at each step; start pulses while busy have no effect.

Source files
------------

// File: rtl/link_align_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : link_align_ctrl
//  Description : Deserializer delay-scan controller. Steps the delay code
//                through every value, pulses the deserializer reset and lets
//                it settle, then judges each code over a dwell window. The
//                centre of the longest run of passing codes is applied and
//                the link is monitored. A sustained loss of alignment starts
//                an automatic rescan.
//  Ports       : clk          - single clock
//                reset        - asynchronous, active-low
//                start        - one-cycle scan request (IDLE / FAIL only)
//                aligned      - alignment flag from the data extractor
//                errorCount   - error counter from the data extractor
//                delay        - delay code driven to the deserializer
//                desrReset    - active-low reset to deserializer/extractor
//                busy         - scan in progress
//                locked       - final delay applied and link aligned
//                fail         - last scan found no passing code
//                bestDelay    - chosen delay code
//                relockCount  - automatic rescans, saturating at 255
//  Revision    : 1.0 - initial release
// ============================================================================
module link_align_ctrl #(
    parameter int DWIDTH  = 6,
    parameter int RSTCYC  = 8,
    parameter int SETTLE  = 64,
    parameter int DWELL   = 256,
    parameter int LOSSCYC = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              aligned,
    input  logic [5:0]        errorCount,
    output logic [DWIDTH-1:0] delay,
    output logic              desrReset,
    output logic              busy,
    output logic              locked,
    output logic              fail,
    output logic [DWIDTH-1:0] bestDelay,
    output logic [7:0]        relockCount
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_RST    = 3'd1;
    localparam logic [2:0] c_SETTLE = 3'd2;
    localparam logic [2:0] c_DWELL  = 3'd3;
    localparam logic [2:0] c_NEXT   = 3'd4;
    localparam logic [2:0] c_APPLY  = 3'd5;
    localparam logic [2:0] c_LOCKED = 3'd6;
    localparam logic [2:0] c_FAIL   = 3'd7;

    // One shared phase counter covers RST, SETTLE and DWELL.
    localparam int c_CMAX_RS = (RSTCYC > SETTLE) ? RSTCYC : SETTLE;
    localparam int c_CMAX    = (c_CMAX_RS > DWELL) ? c_CMAX_RS : DWELL;
    localparam int c_CW      = $clog2(c_CMAX + 1);
    localparam int c_LW      = $clog2(LOSSCYC + 1);

    localparam logic [c_CW-1:0]   c_RST_LAST    = c_CW'(RSTCYC - 1);
    localparam logic [c_CW-1:0]   c_SETTLE_LAST = c_CW'(SETTLE - 1);
    localparam logic [c_CW-1:0]   c_DWELL_LAST  = c_CW'(DWELL - 1);
    localparam logic [c_CW-1:0]   c_CNT_ONE     = c_CW'(1);
    localparam logic [c_LW-1:0]   c_LOSS_LAST   = c_LW'(LOSSCYC - 1);
    localparam logic [c_LW-1:0]   c_LOSS_ONE    = c_LW'(1);
    localparam logic [DWIDTH-1:0] c_TOP         = {DWIDTH{1'b1}};
    localparam logic [DWIDTH-1:0] c_DLY_ONE     = DWIDTH'(1);
    localparam logic [DWIDTH:0]   c_LEN_ONE     = (DWIDTH+1)'(1);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic [2:0]        r_state;
    logic [c_CW-1:0]   r_cnt;
    logic [c_LW-1:0]   r_loss;
    logic [5:0]        r_errSample;
    logic              r_winOk;      // aligned seen high on every dwell cycle so far
    logic              r_pass;       // verdict of the code just judged
    logic              r_applying;   // RST/SETTLE sequence belongs to APPLY
    logic [DWIDTH-1:0] r_curStart;
    logic [DWIDTH:0]   r_curLen;
    logic [DWIDTH-1:0] r_bestStart;
    logic [DWIDTH:0]   r_bestLen;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [DWIDTH-1:0] w_curStart;
    logic [DWIDTH:0]   w_curLen;
    logic [DWIDTH-1:0] w_bestStart;
    logic [DWIDTH:0]   w_bestLen;
    logic [DWIDTH-1:0] w_centre;
    logic [5:0]        w_sample;
    logic              w_launch;
    logic              w_relock;

    // Run tracking for the NEXT state. A strictly longer run is required
    // to replace the best, so ties keep the earlier run. Runs never wrap
    // because the scan stops at the top code.
    always_comb begin
        w_curStart  = r_curStart;
        w_curLen    = r_curLen;
        w_bestStart = r_bestStart;
        w_bestLen   = r_bestLen;
        if (r_pass) begin
            if (r_curLen == '0) begin
                w_curStart = delay;
            end
            w_curLen = r_curLen + c_LEN_ONE;
            if (w_curLen > r_bestLen) begin
                w_bestLen   = w_curLen;
                w_bestStart = w_curStart;
            end
        end else begin
            w_curLen = '0;
        end
    end

    // Floor of the run centre: start + (len-1)/2. The sum never exceeds
    // the last code of the run, so truncation to DWIDTH bits is exact.
    always_comb begin
        w_centre = r_bestStart + DWIDTH'((r_bestLen - c_LEN_ONE) >> 1);
    end

    // The reference error count is taken on the first dwell cycle; on that
    // cycle the live value stands in for the not-yet-stored sample.
    always_comb begin
        w_sample = (r_cnt == '0) ? errorCount : r_errSample;
    end

    always_comb begin
        w_relock = (r_state == c_LOCKED) && !aligned && (r_loss == c_LOSS_LAST);
        w_launch = (((r_state == c_IDLE) || (r_state == c_FAIL)) && start) || w_relock;
    end

    // ------------------------------------------------------------------
    // Main FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= c_IDLE;
            r_cnt       <= '0;
            r_loss      <= '0;
            r_errSample <= '0;
            r_winOk     <= 1'b0;
            r_pass      <= 1'b0;
            r_applying  <= 1'b0;
            r_curStart  <= '0;
            r_curLen    <= '0;
            r_bestStart <= '0;
            r_bestLen   <= '0;
            delay       <= '0;
            desrReset   <= 1'b0;
            busy        <= 1'b0;
            locked      <= 1'b0;
            fail        <= 1'b0;
            bestDelay   <= '0;
            relockCount <= '0;
        end else begin
            // Deserializer reset is released everywhere except while the
            // FSM is (or is about to be) in RST.
            desrReset <= 1'b1;

            if (w_launch) begin
                r_state     <= c_RST;
                r_cnt       <= '0;
                r_loss      <= '0;
                r_applying  <= 1'b0;
                r_curStart  <= '0;
                r_curLen    <= '0;
                r_bestStart <= '0;
                r_bestLen   <= '0;
                delay       <= '0;
                desrReset   <= 1'b0;
                busy        <= 1'b1;
                locked      <= 1'b0;
                fail        <= 1'b0;
                if (w_relock && (relockCount != 8'hFF)) begin
                    relockCount <= relockCount + 8'd1;
                end
            end else begin
                case (r_state)
                    c_IDLE: begin
                        r_cnt <= '0;
                    end

                    c_RST: begin
                        if (r_cnt == c_RST_LAST) begin
                            r_state <= c_SETTLE;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt     <= r_cnt + c_CNT_ONE;
                            desrReset <= 1'b0;
                        end
                    end

                    c_SETTLE: begin
                        if (r_cnt == c_SETTLE_LAST) begin
                            r_cnt <= '0;
                            if (r_applying) begin
                                r_state    <= c_LOCKED;
                                r_applying <= 1'b0;
                                r_loss     <= '0;
                                locked     <= 1'b1;
                                busy       <= 1'b0;
                            end else begin
                                r_state <= c_DWELL;
                                r_winOk <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + c_CNT_ONE;
                        end
                    end

                    c_DWELL: begin
                        r_errSample <= w_sample;
                        if (r_cnt == c_DWELL_LAST) begin
                            r_pass  <= r_winOk && aligned && (errorCount == w_sample);
                            r_state <= c_NEXT;
                            r_cnt   <= '0;
                        end else begin
                            r_winOk <= r_winOk && aligned;
                            r_cnt   <= r_cnt + c_CNT_ONE;
                        end
                    end

                    c_NEXT: begin
                        r_curStart  <= w_curStart;
                        r_curLen    <= w_curLen;
                        r_bestStart <= w_bestStart;
                        r_bestLen   <= w_bestLen;
                        if (delay != c_TOP) begin
                            delay     <= delay + c_DLY_ONE;
                            r_state   <= c_RST;
                            desrReset <= 1'b0;
                        end else if (w_bestLen == '0) begin
                            r_state <= c_FAIL;
                            fail    <= 1'b1;
                            busy    <= 1'b0;
                        end else begin
                            r_state <= c_APPLY;
                        end
                    end

                    c_APPLY: begin
                        bestDelay  <= w_centre;
                        delay      <= w_centre;
                        r_applying <= 1'b1;
                        r_state    <= c_RST;
                        r_cnt      <= '0;
                        desrReset  <= 1'b0;
                    end

                    c_LOCKED: begin
                        if (aligned) begin
                            r_loss <= '0;
                        end else begin
                            r_loss <= r_loss + c_LOSS_ONE;
                        end
                    end

                    c_FAIL: begin
                        r_cnt <= '0;
                    end

                    default: begin
                        r_state <= c_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_link_align_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_link_align_ctrl
//  Description : Self-checking bench for link_align_ctrl. A behavioural link
//                model drives aligned from the current delay code. Expected
//                delay steps and scan outcomes are queued when a scan is
//                requested; independent monitors pop and compare them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_link_align_ctrl;

    localparam int DW     = 6;
    localparam int NCODE  = 1 << DW;
    localparam int RC     = 3;
    localparam int ST     = 5;
    localparam int DL     = 8;
    localparam int LC     = 16;
    localparam int BUDGET = 3000;

    logic             clk        = 1'b0;
    logic             reset      = 1'b1;
    logic             start      = 1'b0;
    logic             force_low  = 1'b0;
    logic [5:0]       errorCount = 6'd17;
    logic [NCODE-1:0] mask       = '0;
    logic             aligned;
    logic [DW-1:0]    delay;
    logic             desrReset;
    logic             busy;
    logic             locked;
    logic             fail;
    logic [DW-1:0]    bestDelay;
    logic [7:0]       relockCount;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_delay_q[$];
    int exp_res_q[$];   // -1 means the scan is expected to fail

    always #5 clk = ~clk;

    // Link model: aligned only for codes in the pass mask.
    assign aligned = !force_low && mask[delay];

    link_align_ctrl #(
        .DWIDTH (DW),
        .RSTCYC (RC),
        .SETTLE (ST),
        .DWELL  (DL),
        .LOSSCYC(LC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .aligned    (aligned),
        .errorCount (errorCount),
        .delay      (delay),
        .desrReset  (desrReset),
        .busy       (busy),
        .locked     (locked),
        .fail       (fail),
        .bestDelay  (bestDelay),
        .relockCount(relockCount)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: list every run of passing codes, pick the first longest.
    function automatic int ref_best(input logic [NCODE-1:0] m);
        int rs[$];
        int rl[$];
        int k;
        int s;
        int pick;
        k = 0;
        while (k < NCODE) begin
            if (m[k]) begin
                s = k;
                while (k < NCODE && m[k]) k++;
                rs.push_back(s);
                rl.push_back(k - s);
            end else begin
                k++;
            end
        end
        if (rs.size() == 0) return -1;
        pick = 0;
        foreach (rl[i]) if (rl[i] > rl[pick]) pick = i;
        return rs[pick] + (rl[pick] - 1) / 2;
    endfunction

    function automatic logic [NCODE-1:0] win(input int lo, input int hi);
        logic [NCODE-1:0] m;
        m = '0;
        for (int k = lo; k <= hi; k++) m[k] = 1'b1;
        return m;
    endfunction

    // ------------------------------------------------------------------
    // Monitor: every deserializer reset pulse must be RC cycles long and
    // must carry the next expected delay code.
    // ------------------------------------------------------------------
    logic prev_dr = 1'b0;
    bit   in_p    = 1'b0;
    int   plen    = 0;
    always @(negedge clk) begin
        if (!reset) begin
            in_p = 1'b0;
        end else begin
            if (prev_dr && !desrReset) begin
                in_p = 1'b1;
                plen = 1;
                if (exp_delay_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_step: delay %0d, no step expected (t=%0t)", delay, $time);
                end else begin
                    chk("step_delay", int'(delay), exp_delay_q.pop_front());
                end
            end else if (in_p && !desrReset) begin
                plen++;
            end else if (in_p && desrReset) begin
                chk("rst_width", plen, RC);
                in_p = 1'b0;
            end
        end
        prev_dr = desrReset;
    end

    // ------------------------------------------------------------------
    // Monitor: scan outcome on each rising locked or fail.
    // ------------------------------------------------------------------
    logic prev_lk = 1'b0;
    logic prev_fl = 1'b0;
    int   e_res;
    always @(negedge clk) begin
        if (reset && ((locked && !prev_lk) || (fail && !prev_fl))) begin
            if (exp_res_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: locked %0d fail %0d, none expected", locked, fail);
            end else begin
                e_res = exp_res_q.pop_front();
                if (e_res < 0) begin
                    chk("fail_flag", int'(fail), 1);
                    chk("fail_locked", int'(locked), 0);
                    chk("fail_busy", int'(busy), 0);
                    chk("fail_delay", int'(delay), NCODE - 1);
                end else begin
                    chk("lock_flag", int'(locked), 1);
                    chk("lock_fail", int'(fail), 0);
                    chk("lock_busy", int'(busy), 0);
                    chk("best_delay", int'(bestDelay), e_res);
                    chk("lock_delay", int'(delay), e_res);
                end
            end
        end
        prev_lk = locked;
        prev_fl = fail;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic expect_scan(input logic [NCODE-1:0] eff);
        int b;
        b = ref_best(eff);
        for (int k = 0; k < NCODE; k++) exp_delay_q.push_back(k);
        if (b >= 0) exp_delay_q.push_back(b);
        exp_res_q.push_back(b);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int c;
        c = 0;
        while (!(locked || fail) && c < BUDGET) begin
            @(negedge clk);
            c++;
        end
        chk("scan_done_in_budget", int'(c < BUDGET), 1);
        @(negedge clk);
    endtask

    task automatic wait_code(input int code);
        int c;
        c = 0;
        while (!(delay == DW'(code) && desrReset) && c < BUDGET) begin
            @(negedge clk);
            c++;
        end
        chk("reach_code", int'(delay), code);
    endtask

    task automatic run_scan(input logic [NCODE-1:0] link, input logic [NCODE-1:0] eff,
                            input int mid_start);
        mask = link;
        expect_scan(eff);
        pulse_start();
        chk("busy_after_start", int'(busy), 1);
        chk("fail_clear_on_start", int'(fail), 0);
        if (mid_start > 0) begin
            repeat (mid_start) @(negedge clk);
            pulse_start();
        end
        wait_done();
    endtask

    task automatic do_reset();
        chk("pending_steps", exp_delay_q.size(), 0);
        chk("pending_results", exp_res_q.size(), 0);
        @(negedge clk);
        #1 reset = 1'b0;
        exp_delay_q.delete();
        exp_res_q.delete();
        force_low = 1'b0;
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_delay"}, int'(delay), 0);
        chk({tag, "_desrReset"}, int'(desrReset), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_locked"}, int'(locked), 0);
        chk({tag, "_fail"}, int'(fail), 0);
        chk({tag, "_bestDelay"}, int'(bestDelay), 0);
        chk({tag, "_relockCount"}, int'(relockCount), 0);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        logic [NCODE-1:0] m;
        int lo;
        int hi;
        int nw;
        int k1;

        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("por");
        #1 reset = 1'b1;
        @(negedge clk);
        chk("desr_after_release", int'(desrReset), 1);
        repeat (5) @(negedge clk);
        chk("idle_no_scan_busy", int'(busy), 0);
        chk("idle_no_scan_delay", int'(delay), 0);

        // Single window 10..20 -> 15, then lock behaviour.
        run_scan(win(10, 20), win(10, 20), 0);
        pulse_start();
        repeat (3) @(negedge clk);
        chk("start_in_locked_locked", int'(locked), 1);
        chk("start_in_locked_busy", int'(busy), 0);

        force_low = 1'b1;
        repeat (LC - 1) @(negedge clk);
        force_low = 1'b0;
        repeat (3) @(negedge clk);
        chk("loss15_locked", int'(locked), 1);
        chk("loss15_relock", int'(relockCount), 0);

        expect_scan(win(10, 20));
        force_low = 1'b1;
        repeat (LC) @(negedge clk);
        force_low = 1'b0;
        chk("loss16_locked", int'(locked), 0);
        chk("loss16_relock", int'(relockCount), 1);
        chk("loss16_delay", int'(delay), 0);
        chk("loss16_busy", int'(busy), 1);
        wait_done();
        chk("relock_count_kept", int'(relockCount), 1);

        // Two windows, and a tie keeps the earlier; start while busy ignored.
        do_reset();
        run_scan(win(5, 8) | win(40, 49), win(5, 8) | win(40, 49), 200);
        do_reset();
        run_scan(win(2, 4) | win(30, 32), win(2, 4) | win(30, 32), 0);

        // No passing code: fail, then a second start rescans.
        do_reset();
        run_scan('0, '0, 0);
        run_scan('0, '0, 0);

        // All-pass, top-code-only and a random single code.
        do_reset();
        run_scan('1, '1, 0);
        do_reset();
        run_scan(win(NCODE - 1, NCODE - 1), win(NCODE - 1, NCODE - 1), 0);
        do_reset();
        k1 = $urandom_range(0, NCODE - 1);
        run_scan(win(k1, k1), win(k1, k1), 0);

        // errorCount moves inside the dwell of code 12.
        do_reset();
        mask = win(10, 20);
        expect_scan(win(10, 11) | win(13, 20));
        pulse_start();
        wait_code(12);
        repeat (ST + 3) @(negedge clk);
        errorCount = errorCount + 6'd1;
        wait_done();

        // Asynchronous reset during the dwell of code 30.
        do_reset();
        mask = '1;
        expect_scan('1);
        pulse_start();
        wait_code(30);
        repeat (ST + 2) @(negedge clk);
        #2 reset = 1'b0;
        #1 chk_reset_vals("midscan");
        exp_delay_q.delete();
        exp_res_q.delete();
        repeat (3) @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("midscan_desr_release", int'(desrReset), 1);
        repeat (10) @(negedge clk);
        chk("midscan_no_restart", int'(busy), 0);

        // Randomized pass masks.
        for (int r = 0; r < 6; r++) begin
            m = '0;
            if (r % 2 == 1) begin
                for (int k = 0; k < NCODE; k++) m[k] = ($urandom_range(0, 3) != 0);
            end else begin
                nw = $urandom_range(1, 3);
                for (int w = 0; w < nw; w++) begin
                    lo = $urandom_range(0, NCODE - 1);
                    hi = lo + $urandom_range(0, 11);
                    if (hi > NCODE - 1) hi = NCODE - 1;
                    m = m | win(lo, hi);
                end
            end
            do_reset();
            run_scan(m, m, 0);
        end

        repeat (3) @(negedge clk);
        chk("final_pending_steps", exp_delay_q.size(), 0);
        chk("final_pending_results", exp_res_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks done", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
